// File: rtl/mips_debug_pkg.sv
// Shared types and constants for the MIPS debug/trace blocks.
package mips_debug_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    FROZEN  = 2'd3
  } trace_state_t;

  // Same NOP rule as the retired-instruction counter.
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] cycle;
  } trace_rec_t;

endpackage

// File: rtl/trace_fifo.sv
// Circular record store with push, pop and overwrite-oldest; show-ahead read at rd_ptr.
module trace_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       overwrite,
  input  logic [95:0]                wr_data,
  output logic [95:0]                rd_data,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [95:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          write;

  // An overwrite writes like a push and retires the oldest entry like a pop.
  assign write   = push || overwrite;
  assign rd_data = mem[rd_ptr];

  // NOTE: the array is deliberately not reset; only pointers and level are,
  // so the storage can map onto plain RAM without a clear sequence.
  always_ff @(posedge clk) begin
    if (write) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (write) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop || overwrite) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        level <= level + 1'b1;
      end else if (pop && !push) begin
        level <= level - 1'b1;
      end
    end
  end

endmodule

// File: rtl/mips_trace_buffer.sv
// Retire-trace capture buffer: arm/trigger FSM, NOP filtering, full-buffer policy
// and saturating overflow counter around a circular record store.
module mips_trace_buffer
  import mips_debug_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int OVF_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    capture_en,
  input  logic                    trigger,
  input  logic                    wrap_mode,
  input  logic                    instr_valid,
  input  logic [31:0]             pc,
  input  logic [31:0]             instruction,
  input  logic [31:0]             cycle_count,
  input  logic                    rd_ready,
  output logic                    rd_valid,
  output logic [31:0]             rd_pc,
  output logic [31:0]             rd_instr,
  output logic [31:0]             rd_cycle,
  output logic [$clog2(DEPTH):0]  level,
  output logic [OVF_W-1:0]        overflow_count,
  output logic [1:0]              state
);

  localparam int LW = $clog2(DEPTH) + 1;

  trace_state_t state_q;
  trace_state_t state_d;
  trace_rec_t   wr_rec;
  trace_rec_t   head_rec;
  trace_rec_t   rd_rec;
  logic [95:0]  fifo_rd;
  logic         qualify;
  logic         window;
  logic         want;
  logic         full;
  logic         pop;
  logic         push;
  logic         overwrite;
  logic         drop;
  logic         ovf_clear;

  assign qualify = instr_valid && (instruction != NOP_WORD);
  // The trigger cycle itself may write, but capture_en=0 always wins.
  assign window  = capture_en && ((state_q == ARMED && trigger) || state_q == CAPTURE);
  assign want    = window && qualify;
  assign full    = (level == LW'(DEPTH));
  assign rd_valid = (level != '0);
  assign pop     = rd_valid && rd_ready;

  assign push      = want && (!full || pop);
  assign overwrite = want && full && !pop && wrap_mode;
  assign drop      = want && full && !pop && !wrap_mode;

  assign wr_rec = '{pc: pc, instr: instruction, cycle: cycle_count};

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .overwrite (overwrite),
    .wr_data   (wr_rec),
    .rd_data   (fifo_rd),
    .level     (level)
  );

  assign head_rec = fifo_rd;
  assign rd_rec   = rd_valid ? head_rec : '0;
  assign rd_pc    = rd_rec.pc;
  assign rd_instr = rd_rec.instr;
  assign rd_cycle = rd_rec.cycle;
  assign state    = state_q;

  // NOTE: every output of this block gets a default before the case, so no
  // path can leave a value unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    ovf_clear = 1'b0;
    case (state_q)
      IDLE: begin
        if (capture_en) begin
          state_d   = ARMED;
          ovf_clear = 1'b1;
        end
      end
      ARMED: begin
        if (!capture_en)  state_d = FROZEN;
        else if (trigger) state_d = CAPTURE;
      end
      CAPTURE: begin
        if (!capture_en) state_d = FROZEN;
      end
      FROZEN: begin
        if (!capture_en && level == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (drop) begin
      state_d = FROZEN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_count <= '0;
    end else if (ovf_clear) begin
      overflow_count <= '0;
    end else if ((overwrite || drop) && overflow_count != '1) begin
      overflow_count <= overflow_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Self-checking bench for mips_trace_buffer: directed scenarios plus a randomized
// run, all checked against a queue-based behavioural model.
module tb_mips_trace_buffer;

  localparam int DEPTH   = 16;
  localparam int OVF_W   = 16;
  localparam int OVF_MAX = (1 << OVF_W) - 1;

  logic        clk;
  logic        rst;
  logic        capture_en;
  logic        trigger;
  logic        wrap_mode;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic [31:0] cycle_count;
  logic        rd_ready;
  logic        rd_valid;
  logic [31:0] rd_pc;
  logic [31:0] rd_instr;
  logic [31:0] rd_cycle;
  logic [4:0]  level;
  logic [OVF_W-1:0] overflow_count;
  logic [1:0]  state;

  mips_trace_buffer #(.DEPTH(DEPTH), .OVF_W(OVF_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .capture_en     (capture_en),
    .trigger        (trigger),
    .wrap_mode      (wrap_mode),
    .instr_valid    (instr_valid),
    .pc             (pc),
    .instruction    (instruction),
    .cycle_count    (cycle_count),
    .rd_ready       (rd_ready),
    .rd_valid       (rd_valid),
    .rd_pc          (rd_pc),
    .rd_instr       (rd_instr),
    .rd_cycle       (rd_cycle),
    .level          (level),
    .overflow_count (overflow_count),
    .state          (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] cyc;
  } rec_t;

  // Model: 0=IDLE 1=ARMED 2=CAPTURE 3=FROZEN, records as a queue, oldest first.
  rec_t m_q[$];
  int   m_state;
  int   m_ovf;
  int   checks;
  int   errors;

  task automatic model_step();
    int   sz;
    int   nst;
    bit   qual;
    bit   popped;
    bit   win;
    rec_t r;
    sz     = m_q.size();
    qual   = instr_valid && (instruction != 32'h0);
    popped = (sz != 0) && rd_ready;
    win    = capture_en && ((m_state == 1 && trigger) || m_state == 2);
    nst    = m_state;
    case (m_state)
      0: if (capture_en) begin nst = 1; m_ovf = 0; end
      1: if (!capture_en) nst = 3; else if (trigger) nst = 2;
      2: if (!capture_en) nst = 3;
      default: if (!capture_en && sz == 0) nst = 0;
    endcase
    if (popped) m_q.delete(0);
    if (win && qual) begin
      r.pc = pc; r.instr = instruction; r.cyc = cycle_count;
      if (sz == DEPTH && !popped) begin
        m_ovf = (m_ovf == OVF_MAX) ? OVF_MAX : m_ovf + 1;
        if (wrap_mode) begin
          m_q.delete(0);
          m_q.push_back(r);
        end else begin
          nst = 3;
        end
      end else begin
        m_q.push_back(r);
      end
    end
    m_state = nst;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    instr_valid = 1'b0;
    trigger     = 1'b0;
    rd_ready    = 1'b0;
  endtask

  task automatic retire(input logic [31:0] p, input logic [31:0] w);
    instr_valid = 1'b1;
    pc          = p;
    instruction = w;
    cycle_count = $urandom;
  endtask

  task automatic test_reset();
    rst = 1'b1; capture_en = 1'b0; wrap_mode = 1'b0;
    pc = '0; instruction = '0; cycle_count = '0;
    quiet();
    m_q.delete(); m_state = 0; m_ovf = 0;
    #2;
    checks++;
    if (state !== 2'd0 || level !== 5'd0 || rd_valid !== 1'b0 || overflow_count !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: state=%0d level=%0d rd_valid=%0b ovf=%0d, want all 0",
               state, level, rd_valid, overflow_count);
    end
    checks++;
    if (rd_pc !== '0 || rd_instr !== '0 || rd_cycle !== '0) begin
      errors++;
      $display("FAIL reset_data: rd_pc=%h rd_instr=%h rd_cycle=%h, want 0", rd_pc, rd_instr, rd_cycle);
    end
    #10 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_arm();
    capture_en = 1'b1;
    tick();
    checks++;
    if (state !== 2'd1) begin
      errors++; $display("FAIL arm_state: state=%0d want 1", state);
    end
    for (int i = 0; i < 3; i++) begin
      retire(32'h100 + 32'(4 * i), 32'h2402_0001 + 32'(i));
      tick();
    end
    quiet();
    checks++;
    if (level !== 5'd0 || state !== 2'd1) begin
      errors++; $display("FAIL armed_no_write: level=%0d state=%0d want 0/1", level, state);
    end
  endtask

  task automatic test_trigger_nop();
    logic [31:0] exp_pc [4];
    exp_pc[0] = 32'h0; exp_pc[1] = 32'h4; exp_pc[2] = 32'hC; exp_pc[3] = 32'h10;
    for (int i = 0; i < 5; i++) begin
      retire(32'(4 * i), (i == 2) ? 32'h0 : ($urandom | 32'h1));
      trigger = (i == 0);
      tick();
    end
    quiet();
    checks++;
    if (level !== 5'd4 || state !== 2'd2) begin
      errors++; $display("FAIL nop_level: level=%0d state=%0d want 4/2", level, state);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (!rd_valid || rd_pc !== exp_pc[k] || rd_instr !== m_q[0].instr || rd_cycle !== m_q[0].cyc) begin
        errors++;
        $display("FAIL nop_drain[%0d]: valid=%0b pc=%h instr=%h cyc=%h want pc=%h instr=%h cyc=%h",
                 k, rd_valid, rd_pc, rd_instr, rd_cycle, exp_pc[k], m_q[0].instr, m_q[0].cyc);
      end
      rd_ready = 1'b1;
      tick();
    end
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    checks++;
    if (rd_valid !== 1'b0 || rd_pc !== '0 || level !== 5'd0) begin
      errors++; $display("FAIL empty_ready: valid=%0b pc=%h level=%0d want 0", rd_valid, rd_pc, level);
    end
    capture_en = 1'b0;
    tick();
    tick();
    checks++;
    if (state !== 2'd0) begin
      errors++; $display("FAIL back_to_idle: state=%0d want 0", state);
    end
  endtask

  task automatic test_stop_full();
    wrap_mode = 1'b0; capture_en = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      retire(32'h1000 + 32'(4 * i), $urandom | 32'h1);
      trigger = (i == 0);
      tick();
    end
    quiet();
    checks++;
    if (level !== 5'd16 || overflow_count !== 16'd1 || state !== 2'd3) begin
      errors++;
      $display("FAIL stop_full: level=%0d ovf=%0d state=%0d want 16/1/3", level, overflow_count, state);
    end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (!rd_valid || rd_pc !== 32'h1000 + 32'(4 * k) || rd_cycle !== m_q[0].cyc) begin
        errors++;
        $display("FAIL stop_drain[%0d]: valid=%0b pc=%h cyc=%h want pc=%h cyc=%h",
                 k, rd_valid, rd_pc, rd_cycle, 32'h1000 + 32'(4 * k), m_q[0].cyc);
      end
      rd_ready = 1'b1;
      tick();
    end
    rd_ready = 1'b0; capture_en = 1'b0;
    tick();
    checks++;
    if (state !== 2'd0 || level !== 5'd0) begin
      errors++; $display("FAIL stop_idle: state=%0d level=%0d want 0/0", state, level);
    end
  endtask

  task automatic test_wrap();
    wrap_mode = 1'b1; capture_en = 1'b1;
    tick();
    checks++;
    if (overflow_count !== '0) begin
      errors++; $display("FAIL ovf_clear_on_arm: ovf=%0d want 0", overflow_count);
    end
    for (int i = 0; i < 20; i++) begin
      retire(32'h2000 + 32'(4 * i), $urandom | 32'h1);
      trigger = (i == 0);
      tick();
    end
    quiet();
    checks++;
    if (level !== 5'd16 || overflow_count !== 16'd4 || state !== 2'd2 || rd_pc !== 32'h2010) begin
      errors++;
      $display("FAIL wrap: level=%0d ovf=%0d state=%0d head=%h want 16/4/2/00002010",
               level, overflow_count, state, rd_pc);
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_pc !== 32'h2000 + 32'(4 * (4 + i))) begin
        errors++; $display("FAIL pushpop_head[%0d]: pc=%h want %h", i, rd_pc, 32'h2000 + 32'(4 * (4 + i)));
      end
      retire(32'h3000 + 32'(4 * i), $urandom | 32'h1);
      rd_ready = 1'b1;
      tick();
    end
    quiet();
    checks++;
    if (level !== 5'd16 || overflow_count !== 16'd4) begin
      errors++; $display("FAIL pushpop_full: level=%0d ovf=%0d want 16/4", level, overflow_count);
    end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (!rd_valid || rd_pc !== m_q[0].pc || rd_instr !== m_q[0].instr || rd_cycle !== m_q[0].cyc) begin
        errors++;
        $display("FAIL wrap_drain[%0d]: pc=%h instr=%h cyc=%h want %h %h %h",
                 k, rd_pc, rd_instr, rd_cycle, m_q[0].pc, m_q[0].instr, m_q[0].cyc);
      end
      rd_ready = 1'b1;
      tick();
    end
    rd_ready = 1'b0; capture_en = 1'b0;
    tick();
    tick();
    checks++;
    if (state !== 2'd0) begin
      errors++; $display("FAIL wrap_idle: state=%0d want 0", state);
    end
  endtask

  task automatic test_shutdown();
    wrap_mode = 1'b0; capture_en = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      retire(32'h4000 + 32'(4 * i), $urandom | 32'h1);
      trigger = (i == 0);
      tick();
    end
    quiet();
    capture_en = 1'b0;
    tick();
    checks++;
    if (state !== 2'd3 || level !== 5'd3) begin
      errors++; $display("FAIL shutdown: state=%0d level=%0d want 3/3", state, level);
    end
    capture_en = 1'b1;
    tick();
    checks++;
    if (state !== 2'd3) begin
      errors++; $display("FAIL frozen_rearm: state=%0d want 3", state);
    end
    capture_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rd_pc !== 32'h4000 + 32'(4 * k) || rd_cycle !== m_q[0].cyc) begin
        errors++; $display("FAIL shutdown_drain[%0d]: pc=%h cyc=%h want %h %h",
                           k, rd_pc, rd_cycle, 32'h4000 + 32'(4 * k), m_q[0].cyc);
      end
      rd_ready = 1'b1;
      tick();
    end
    rd_ready = 1'b0;
    tick();
    checks++;
    if (state !== 2'd0 || level !== 5'd0) begin
      errors++; $display("FAIL shutdown_idle: state=%0d level=%0d want 0/0", state, level);
    end
  endtask

  task automatic test_reset_mid();
    capture_en = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      retire(32'h5000 + 32'(4 * i), $urandom | 32'h1);
      trigger = (i == 0);
      tick();
    end
    quiet();
    checks++;
    if (level !== 5'd5 || state !== 2'd2) begin
      errors++; $display("FAIL pre_reset: level=%0d state=%0d want 5/2", level, state);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (level !== 5'd0 || rd_valid !== 1'b0 || state !== 2'd0 || rd_pc !== '0) begin
      errors++; $display("FAIL async_reset: level=%0d valid=%0b state=%0d pc=%h want 0",
                         level, rd_valid, state, rd_pc);
    end
    m_q.delete(); m_state = 0; m_ovf = 0;
    capture_en = 1'b0;
    #2 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] e_pc, e_in, e_cy;
    for (int i = 0; i < 600; i++) begin
      if ((i / 80) % 2 == 1) begin
        capture_en = ($urandom % 8) == 0;
        rd_ready   = ($urandom % 4) != 0;
      end else begin
        capture_en = ($urandom % 20) != 0;
        rd_ready   = ($urandom % 3) == 0;
      end
      trigger     = ($urandom % 4) == 0;
      if ($urandom % 32 == 0) wrap_mode = ~wrap_mode;
      instr_valid = ($urandom % 4) != 0;
      instruction = ($urandom % 5 == 0) ? 32'h0 : $urandom;
      pc          = $urandom;
      cycle_count = $urandom;
      tick();
      if (m_q.size() != 0) begin
        e_pc = m_q[0].pc; e_in = m_q[0].instr; e_cy = m_q[0].cyc;
      end else begin
        e_pc = '0; e_in = '0; e_cy = '0;
      end
      checks++;
      if (state !== 2'(m_state) || level !== 5'(m_q.size()) || overflow_count !== OVF_W'(m_ovf)) begin
        errors++;
        $display("FAIL rand_ctrl[%0d]: state=%0d level=%0d ovf=%0d want %0d %0d %0d",
                 i, state, level, overflow_count, m_state, m_q.size(), m_ovf);
      end
      checks++;
      if (rd_valid !== (m_q.size() != 0) || rd_pc !== e_pc || rd_instr !== e_in || rd_cycle !== e_cy) begin
        errors++;
        $display("FAIL rand_head[%0d]: valid=%0b pc=%h instr=%h cyc=%h want %h %h %h",
                 i, rd_valid, rd_pc, rd_instr, rd_cycle, e_pc, e_in, e_cy);
      end
    end
    quiet();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_arm();
    test_trigger_nop();
    test_stop_full();
    test_wrap();
    test_full_push_pop();
    test_shutdown();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mips_trace_buffer.md
# mips_trace_buffer

Retire-trace capture buffer that sits directly downstream of the MIPS debug counters. Each cycle it samples the retiring instruction word, its PC and the free-running cycle count, and stores qualifying records in a circular buffer after an arm/trigger sequence. A debug host drains the buffer through a show-ahead valid/ready port. Records carry the same NOP rule as the instruction counter: the word 0x00000000 is never recorded.

## Interface
- DEPTH, 16, number of record slots; must be a power of two, at least 4.
- OVF_W, 16, width of the saturating overflow counter.
- clk  in  1  clock.
- rst  in  1  reset: asynchronous, active-high.
- capture_en  in  1  level-sensitive session enable.
- trigger  in  1  start-capture pulse; sampled only in ARMED.
- wrap_mode  in  1  full-buffer policy: 0 = stop-when-full, 1 = overwrite oldest. Sampled every cycle.
- instr_valid  in  1  retire strobe for the current instruction.
- pc  in  32  PC of the retiring instruction.
- instruction  in  32  retiring instruction word.
- cycle_count  in  32  cycle stamp from the debug counter.
- rd_ready  in  1  host accepts the head record.
- rd_valid  out  1  head record available.
- rd_pc, rd_instr, rd_cycle  out  32 each  head record fields.
- level  out  $clog2(DEPTH)+1  records currently held.
- overflow_count  out  OVF_W  records dropped or overwritten; saturates at all-ones.
- state  out  2  FSM state: IDLE=0, ARMED=1, CAPTURE=2, FROZEN=3.

## Operation
- **Qualifying record:** `instr_valid && instruction != 32'h0`. The stored record is {pc, instruction, cycle_count} as sampled that cycle.
- **IDLE:**
  - capture_en=1 -> ARMED.
  - No writes.
- **ARMED:**
  - No writes except on the trigger cycle.
  - trigger=1 -> CAPTURE. A qualifying record on the trigger cycle is written.
  - capture_en=0 -> FROZEN.
  - If capture_en=0 and trigger=1 arrive together, FROZEN wins and nothing is written.
- **CAPTURE:** every qualifying record is pushed.
  - capture_en=0 -> FROZEN. Nothing is written on that cycle.
- **Full buffer in CAPTURE (level==DEPTH, no pop that cycle):**
  - wrap_mode=0: the record is dropped, overflow_count +1, and the state goes to FROZEN.
  - wrap_mode=1: the oldest record is discarded, the new one is written, level stays at DEPTH, overflow_count +1, and the state stays CAPTURE.
- **Full buffer with a simultaneous pop:** the pop and the push both happen. level is unchanged and there is no overflow.
- **FROZEN:**
  - No writes.
  - capture_en=0 and level==0 -> IDLE.
  - capture_en=1 while FROZEN is ignored. Re-arming requires passing through IDLE.
- **Read port (all states):**
  - rd_valid = (level != 0).
  - A pop occurs when rd_valid && rd_ready.
  - rd_ready while empty has no effect.
  - rd_* show the head record and are forced to 0 when rd_valid=0.
- **Arithmetic:**
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
  - level is updated by +1 (push), -1 (pop), 0 (push and pop, or neither).
  - overflow_count holds at all-ones once saturated.
- **Session behaviour:**
  - overflow_count clears on the IDLE->ARMED transition. Otherwise it is cleared only by reset.
  - Buffer contents persist across sessions until drained.

## Timing
- **Reset values:** state=IDLE, level=0, rd_valid=0, rd_pc/rd_instr/rd_cycle=0, overflow_count=0.
- **Reset mid-operation:** pointers, level, counter and state clear immediately (asynchronous). Array contents need not be cleared.
- **Write latency:** a push on edge N makes level and rd_valid reflect it after edge N; this is visible in cycle N+1.
- **Read path:** show-ahead and combinational from the array at the read pointer. A pop at edge N presents the next record, or rd_valid=0, in cycle N+1.
- **FSM:** all transitions are registered, with one-cycle granularity. A push decision uses the state in effect before the edge.

## Structure
- **Shared package `mips_debug_pkg`:**
  - trace_state_t enum (IDLE/ARMED/CAPTURE/FROZEN).
  - NOP_WORD = 32'h0000_0000.
  - trace_rec_t packed struct {pc, instr, cycle}.
- **Sub-module `trace_fifo`:** storage array, read/write pointers and level, with push, pop and overwrite inputs.
- **Top:** FSM, qualification logic and overflow counter.

## Test plan
- **Reset and arm:** reset -> all outputs 0 and state=0. Raise capture_en -> state=1 next cycle. Three qualifying retires with no trigger -> level stays 0.
- **Trigger and NOP filter:** trigger plus 5 retires (pc 0x0,0x4,0x8,0xC,0x10), where the 0x8 retire has instruction=0 -> level=4. Drain returns pc 0x0,0x4,0xC,0x10 with the matching cycle_count.
- **Stop-when-full:** wrap_mode=0, DEPTH=16, 20 qualifying retires -> level=16, overflow_count=1, state=FROZEN. Drain yields the first 16 records.
- **Wrap mode:** wrap_mode=1, 20 retires -> level=16, overflow_count=4, state=CAPTURE. Drain yields records 5..20 in order.
- **Full with simultaneous push and pop:** rd_ready=1 while full and pushing -> level stays 16, overflow_count unchanged.
- **Shutdown and reset mid-capture:**
  - Drop capture_en while 3 records are held -> FROZEN; drain 3 -> IDLE.
  - Separately, assert rst mid-CAPTURE -> level=0, rd_valid=0, state=IDLE immediately.
